// File: rtl/id_stage_hz_if.sv
// ----------------------------------------------------------------------------
// id_stage_hz_if
// Bundles every signal of the hazard-aware decode stage except clk/reset.
//   IF/ID side : in_valid, in_instr, in_pc -> in_ready
//   control    : flush, ex_mem_read, ex_rd_addr
//   WB port    : wb_reg_write, wb_rd_addr, wb_rd_data
//   ID/EX side : out_ready -> out_valid, out_pc, out_instr, out_rs1_data,
//                out_rs2_data, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm
//   status     : stall_cnt (load-use bubbles, saturating)
// The slave modport is the decode stage; master is the surrounding pipeline.
// ----------------------------------------------------------------------------
interface id_stage_hz_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             in_ready;
    logic             flush;
    logic             ex_mem_read;
    logic [4:0]       ex_rd_addr;
    logic             wb_reg_write;
    logic [4:0]       wb_rd_addr;
    logic [XLEN-1:0]  wb_rd_data;
    logic             out_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_rs1_data;
    logic [XLEN-1:0]  out_rs2_data;
    logic [4:0]       out_rs1_addr;
    logic [4:0]       out_rs2_addr;
    logic [4:0]       out_rd_addr;
    logic [XLEN-1:0]  out_imm;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, ex_mem_read, ex_rd_addr,
               wb_reg_write, wb_rd_addr, wb_rd_data, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1_data,
               out_rs2_data, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_imm, stall_cnt
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, ex_mem_read, ex_rd_addr,
               wb_reg_write, wb_rd_addr, wb_rd_data, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1_data,
               out_rs2_data, out_rs1_addr, out_rs2_addr, out_rd_addr,
               out_imm, stall_cnt
    );
endinterface

// File: rtl/id_stage_hz.sv
// ----------------------------------------------------------------------------
// id_stage_hz
// Handshaked RV32 decode stage: register file (x0 = 0, optional WB
// write-through), immediate generation, load-use bubble insertion, flush,
// downstream backpressure and a registered ID/EX output with a valid bit.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, highest priority
//   bus   - id_stage_hz_if.slave carrying the IF/ID, control, WB and ID/EX
//           signals (see the interface header)
// ----------------------------------------------------------------------------
module id_stage_hz #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    id_stage_hz_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000,
        OPC_OP_IMM = 5'b00100,
        OPC_AUIPC  = 5'b00101,
        OPC_STORE  = 5'b01000,
        OPC_OP     = 5'b01100,
        OPC_LUI    = 5'b01101,
        OPC_BRANCH = 5'b11000,
        OPC_JALR   = 5'b11001,
        OPC_JAL    = 5'b11011
    } opcode_e;

    logic [XLEN-1:0] regs [NREG];

    opcode_e         opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            uses_rs1, uses_rs2;
    logic            wb_en;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            load_use, advance;

    // Indices at or above NREG name no register (RV32E encodings x16..x31).
    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < NREG;
    endfunction

    // Read-port select: x0/out-of-range read 0, optional write-through.
    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      a,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wd
    );
        if (a == 5'd0 || !in_range(a)) return '0;
        if (WB_BYPASS && we && wa == a) return wd;
        return stored;
    endfunction

    assign wb_en = bus.wb_reg_write && bus.wb_rd_addr != 5'd0 && in_range(bus.wb_rd_addr);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        opcode   = opcode_e'(bus.in_instr[6:2]);
        rs1      = bus.in_instr[19:15];
        rs2      = bus.in_instr[24:20];
        rd       = bus.in_instr[11:7];
        imm32    = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            OPC_STORE: begin
                imm32    = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
                uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                imm32    = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                            bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32    = {bus.in_instr[31:12], 12'b0};
                uses_rs1 = 1'b0;
            end
            OPC_JAL: begin
                imm32    = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                            bus.in_instr[20], bus.in_instr[30:21], 1'b0};
                uses_rs1 = 1'b0;
            end
            OPC_OP:
                uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    assign imm_ext = XLEN'($signed(imm32));

    assign rs1_data = read_port(rs1, regs[rs1[AW-1:0]], wb_en, bus.wb_rd_addr, bus.wb_rd_data);
    assign rs2_data = read_port(rs2, regs[rs2[AW-1:0]], wb_en, bus.wb_rd_addr, bus.wb_rd_data);

    assign load_use = bus.in_valid && bus.ex_mem_read && bus.ex_rd_addr != 5'd0 &&
                      ((uses_rs1 && rs1 == bus.ex_rd_addr) ||
                       (uses_rs2 && rs2 == bus.ex_rd_addr));
    assign advance      = bus.out_ready || !bus.out_valid;
    // A flush discards IF/ID, so it is consumed regardless of stalls.
    assign bus.in_ready = bus.flush || (advance && !load_use);

    // NOTE: the register file is cleared on reset so that every entry reads a
    // defined zero afterwards; entry 0 is never written and stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[bus.wb_rd_addr[AW-1:0]] <= bus.wb_rd_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_instr    <= '0;
            bus.out_rs1_data <= '0;
            bus.out_rs2_data <= '0;
            bus.out_rs1_addr <= '0;
            bus.out_rs2_addr <= '0;
            bus.out_rd_addr  <= '0;
            bus.out_imm      <= '0;
            bus.stall_cnt    <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (!advance) begin
            // EX is holding the current output; keep everything.
        end else if (load_use) begin
            bus.out_valid <= 1'b0;
            if (bus.stall_cnt != {CNT_W{1'b1}}) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
        end else begin
            // Fields are captured even for an invalid slot; out_valid masks them.
            bus.out_valid    <= bus.in_valid;
            bus.out_pc       <= bus.in_pc;
            bus.out_instr    <= bus.in_instr;
            bus.out_rs1_data <= rs1_data;
            bus.out_rs2_data <= rs2_data;
            bus.out_rs1_addr <= rs1;
            bus.out_rs2_addr <= rs2;
            bus.out_rd_addr  <= rd;
            bus.out_imm      <= imm_ext;
        end
    end
endmodule

// File: tb/tb_id_stage_hz.sv
// ----------------------------------------------------------------------------
// tb_id_stage_hz
// Directed bench for id_stage_hz. Three instances share one stimulus stream:
//   dut_m : defaults (NREG=32, WB_BYPASS=1, CNT_W=32)
//   dut_n : WB_BYPASS=0
//   dut_e : NREG=16 (RV32E), CNT_W=2 to reach stall-counter saturation
// ----------------------------------------------------------------------------
module tb_id_stage_hz;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_addr;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic        out_ready;

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] ADD_X1_X5  = 32'h000280B3;
    localparam logic [31:0] ADD_X1_X7  = 32'h000380B3;
    localparam logic [31:0] ADD_X1_X20 = 32'h000A00B3;
    localparam logic [31:0] ADD_X1_X4  = 32'h000200B3;
    localparam logic [31:0] ADD_X1_X0  = 32'h000000B3;
    localparam logic [31:0] SW_X3_X2   = 32'h00312023;
    localparam logic [31:0] LUI_X3     = 32'h000181B7;  // rs1 field = 3
    localparam logic [31:0] BEQ_M4     = 32'hFE000EE3;
    localparam logic [31:0] JAL_2048   = 32'h0010006F;
    localparam logic [31:0] ADDI_M1    = 32'hFFF00113;

    id_stage_hz_if #(.XLEN(32), .CNT_W(32)) if_m ();
    id_stage_hz_if #(.XLEN(32), .CNT_W(32)) if_n ();
    id_stage_hz_if #(.XLEN(32), .CNT_W(2))  if_e ();

    assign if_m.in_valid = in_valid, if_m.in_instr = in_instr, if_m.in_pc = in_pc,
           if_m.flush = flush, if_m.ex_mem_read = ex_mem_read, if_m.ex_rd_addr = ex_rd_addr,
           if_m.wb_reg_write = wb_reg_write, if_m.wb_rd_addr = wb_rd_addr,
           if_m.wb_rd_data = wb_rd_data, if_m.out_ready = out_ready;
    assign if_n.in_valid = in_valid, if_n.in_instr = in_instr, if_n.in_pc = in_pc,
           if_n.flush = flush, if_n.ex_mem_read = ex_mem_read, if_n.ex_rd_addr = ex_rd_addr,
           if_n.wb_reg_write = wb_reg_write, if_n.wb_rd_addr = wb_rd_addr,
           if_n.wb_rd_data = wb_rd_data, if_n.out_ready = out_ready;
    assign if_e.in_valid = in_valid, if_e.in_instr = in_instr, if_e.in_pc = in_pc,
           if_e.flush = flush, if_e.ex_mem_read = ex_mem_read, if_e.ex_rd_addr = ex_rd_addr,
           if_e.wb_reg_write = wb_reg_write, if_e.wb_rd_addr = wb_rd_addr,
           if_e.wb_rd_data = wb_rd_data, if_e.out_ready = out_ready;

    id_stage_hz #(.XLEN(32), .NREG(32), .WB_BYPASS(1'b1), .CNT_W(32))
        dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));
    id_stage_hz #(.XLEN(32), .NREG(32), .WB_BYPASS(1'b0), .CNT_W(32))
        dut_n (.clk(clk), .reset(reset), .bus(if_n.slave));
    id_stage_hz #(.XLEN(32), .NREG(16), .WB_BYPASS(1'b1), .CNT_W(2))
        dut_e (.clk(clk), .reset(reset), .bus(if_e.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply an IF/ID instruction and let combinational outputs settle.
    task automatic issue(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_reg_write = we;
        wb_rd_addr   = a;
        wb_rd_data   = d;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rd_addr = '0; out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        tick(); tick();
        check("reset_valid", if_m.out_valid, 0);
        check("reset_pc", if_m.out_pc, 0);
        check("reset_stall", if_m.stall_cnt, 0);
        reset = 1'b0;

        // Write x5 = 0x1234, then read it with ADD x1,x5,x0.
        wb(1'b1, 5'd5, 32'h1234); tick();
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b1, ADD_X1_X5, 32'h100);
        check("add_in_ready", if_m.in_ready, 1);
        tick();
        check("add_valid", if_m.out_valid, 1);
        check("add_rs1", if_m.out_rs1_data, 32'h1234);
        check("add_rs2", if_m.out_rs2_data, 0);
        check("add_rd", if_m.out_rd_addr, 1);
        check("add_pc", if_m.out_pc, 32'h100);
        check("add_rs1_addr", if_m.out_rs1_addr, 5);

        // Same-cycle WB write of x7 while ID reads x7.
        wb(1'b1, 5'd7, 32'hDEAD);
        issue(1'b1, ADD_X1_X7, 32'h104);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("bypass_on", if_m.out_rs1_data, 32'hDEAD);
        check("bypass_off", if_n.out_rs1_data, 0);
        tick();
        check("nobyp_after_write", if_n.out_rs1_data, 32'hDEAD);

        // Load-use: SW x3,0(x2) behind a load to x3.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd3;
        issue(1'b1, SW_X3_X2, 32'h108);
        check("lu_in_ready", if_m.in_ready, 0);
        tick();
        check("lu_bubble", if_m.out_valid, 0);
        check("lu_stall_cnt", if_m.stall_cnt, 1);
        ex_mem_read = 1'b0;
        #1;
        check("lu_release_ready", if_m.in_ready, 1);
        tick();
        check("lu_issue_valid", if_m.out_valid, 1);
        check("lu_issue_instr", if_m.out_instr, SW_X3_X2);
        check("lu_issue_rs2_addr", if_m.out_rs2_addr, 3);

        // LUI x3 does not read registers: no stall.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd3;
        issue(1'b1, LUI_X3, 32'h10C);
        check("lui_in_ready", if_m.in_ready, 1);
        tick();
        ex_mem_read = 1'b0;
        check("lui_valid", if_m.out_valid, 1);
        check("lui_stall_cnt", if_m.stall_cnt, 1);
        check("lui_imm", if_m.out_imm, 32'h00018000);

        // Backpressure: hold for three cycles, then release.
        out_ready = 1'b0;
        issue(1'b1, ADD_X1_X5, 32'h200);
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", if_m.in_ready, 0);
            tick();
            check("hold_valid", if_m.out_valid, 1);
            check("hold_pc", if_m.out_pc, 32'h10C);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", if_m.in_ready, 1);
        tick();
        check("release_pc", if_m.out_pc, 32'h200);
        check("release_rs1", if_m.out_rs1_data, 32'h1234);

        // Flush with load_use and out_ready=0 at the same time.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd3; out_ready = 1'b0; flush = 1'b1;
        issue(1'b1, SW_X3_X2, 32'h204);
        check("flush_in_ready", if_m.in_ready, 1);
        tick();
        check("flush_valid", if_m.out_valid, 0);
        check("flush_stall_cnt", if_m.stall_cnt, 1);
        ex_mem_read = 1'b0; out_ready = 1'b1; flush = 1'b0;

        // RV32E: x20 is not a register, x0 ignores writes.
        wb(1'b1, 5'd20, 32'hAAAA);
        issue(1'b1, ADD_X1_X20, 32'h300);
        tick();
        check("e_x20_bypass", if_e.out_rs1_data, 0);
        check("m_x20_bypass", if_m.out_rs1_data, 32'hAAAA);
        wb(1'b0, 5'd0, 32'h0);
        issue(1'b1, ADD_X1_X4, 32'h304);
        tick();
        check("e_x4_no_alias", if_e.out_rs1_data, 0);
        wb(1'b1, 5'd0, 32'hFF);
        issue(1'b1, ADD_X1_X0, 32'h308);
        tick();
        check("x0_bypass_m", if_m.out_rs1_data, 0);
        check("x0_bypass_e", if_e.out_rs1_data, 0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        check("x0_stored_m", if_m.out_rs1_data, 0);
        issue(1'b1, ADD_X1_X20, 32'h30C);
        tick();
        check("e_x20_read", if_e.out_rs1_data, 0);
        check("n_x20_read", if_n.out_rs1_data, 32'hAAAA);

        // Immediates.
        issue(1'b1, BEQ_M4, 32'h400);   tick();
        check("imm_beq", if_m.out_imm, 32'hFFFFFFFC);
        issue(1'b1, JAL_2048, 32'h404); tick();
        check("imm_jal", if_m.out_imm, 32'h00000800);
        issue(1'b1, ADDI_M1, 32'h408);  tick();
        check("imm_addi", if_m.out_imm, 32'hFFFFFFFF);
        check("addi_rd", if_m.out_rd_addr, 2);

        // Four back-to-back bubbles: the 2-bit counter saturates at 3.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd3;
        issue(1'b1, SW_X3_X2, 32'h500);
        tick(); tick();
        check("e_stall_2", if_e.stall_cnt, 3);
        tick(); tick();
        check("e_stall_sat", if_e.stall_cnt, 3);
        check("m_stall_5", if_m.stall_cnt, 5);
        ex_mem_read = 1'b0;

        // Reset beats flush and clears the register file.
        reset = 1'b1; flush = 1'b1;
        issue(1'b1, ADD_X1_X5, 32'h600);
        tick();
        check("rst2_valid", if_m.out_valid, 0);
        check("rst2_stall", if_m.stall_cnt, 0);
        check("rst2_imm", if_m.out_imm, 0);
        reset = 1'b0; flush = 1'b0;
        #1;
        tick();
        check("rst2_add_valid", if_m.out_valid, 1);
        check("rst2_x5_cleared", if_m.out_rs1_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised, handshaked decode stage for the 5-stage RV32 pipeline; successor to the plain ID stage.
- Contains the register file (configurable depth, x0 hardwired to 0) and immediate generation.
- Adds load-use hazard detection with bubble insertion, WB-to-ID write-through bypass, flush, downstream backpressure, and a registered ID/EX output with a valid bit.
- Sits between the IF/ID register and EX; EX-side forwarding stays in EX.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- NREG, 32, architectural register count (16 for RV32E, 32 otherwise); AW = $clog2(NREG).
- WB_BYPASS, 1, 1 = a same-cycle WB write to a register being read returns wb_rd_data.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- in_ready  out  1  ID consumes the current IF/ID contents this cycle
- flush  in  1  branch/jump redirect; kill ID contents and output
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd_addr  in  5  destination register of the instruction in EX
- wb_reg_write  in  1  WB write enable
- wb_rd_addr  in  5  WB destination register
- wb_rd_data  in  XLEN  WB write data
- out_ready  in  1  EX accepts the ID/EX register
- out_valid  out  1  ID/EX register valid
- out_pc  out  XLEN  registered PC
- out_instr  out  32  registered instruction (EX controller decodes it)
- out_rs1_data  out  XLEN  registered rs1 operand
- out_rs2_data  out  XLEN  registered rs2 operand
- out_rs1_addr  out  5  registered rs1 index (for EX forwarding)
- out_rs2_addr  out  5  registered rs2 index (for EX forwarding)
- out_rd_addr  out  5  registered rd index
- out_imm  out  XLEN  registered sign-extended immediate
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous, active-high, and has priority over every other input.
  - On reset: out_valid=0, all out_* data fields=0, every register-file entry=0, stall_cnt=0.
- Register file:
  - NREG x XLEN storage; write occurs on the clk edge when wb_reg_write=1, wb_rd_addr!=0 and wb_rd_addr<NREG.
  - Reads are combinational. Index 0, or any index >=NREG, reads 0.
  - With WB_BYPASS=1, a read whose index equals a valid same-cycle write index (nonzero, <NREG) returns wb_rd_data.
- Immediate generation (from opcode in_instr[6:2]):
  - I-type (OP-IMM, LOAD, JALR), S-type (STORE), B-type (BRANCH), U-type (LUI, AUIPC), J-type (JAL), all sign-extended to XLEN.
  - Any other opcode gives imm=0.
- Source usage:
  - uses_rs1 = 1 except for LUI, AUIPC and JAL.
  - uses_rs2 = 1 only for OP, STORE and BRANCH.
- Hazard detection:
  - load_use = in_valid & ex_mem_read & ex_rd_addr!=0 & ((uses_rs1 & rs1==ex_rd_addr) | (uses_rs2 & rs2==ex_rd_addr)).
- Handshake and advance:
  - advance = out_ready | ~out_valid.
  - in_ready = flush | (advance & ~load_use).
- ID/EX register update on a clk edge (reset excluded), first matching case wins:
  - flush=1: out_valid<=0; data fields don't-care (implementation holds them).
  - ~advance: all outputs hold.
  - load_use=1: out_valid<=0 (bubble), IF/ID not consumed, stall_cnt increments.
  - otherwise: out_valid<=in_valid and all fields are captured. Fields are captured even when in_valid=0; they are ignored while out_valid=0.
- Latency and ordering:
  - Latency is 1 cycle from acceptance to out_valid.
  - A held output (out_ready=0) is not refreshed by later WB writes; EX forwarding covers this case.
- Stall counter: stall_cnt saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - flush together with load_use: flush wins; no bubble is counted.
  - flush together with out_ready=0: the output is still killed.

Test Plan:
- Reset then write x5=0x1234 via WB, then issue ADD x1,x5,x0 with in_valid=1 -> next cycle out_valid=1, out_rs1_data=0x1234, out_rs2_data=0, out_rd_addr=1.
- Same cycle WB writes x7=0xDEAD while ID reads x7, WB_BYPASS=1 -> out_rs1_data=0xDEAD; with WB_BYPASS=0 -> old value 0.
- ex_mem_read=1, ex_rd_addr=3, ID holds SW x3,0(x2) -> in_ready=0, next out_valid=0, stall_cnt=1; then drop ex_mem_read -> instruction issues with out_valid=1. Repeat with LUI x3 (no source use) -> no stall.
- out_ready=0 with out_valid=1 for 3 cycles -> outputs frozen, in_ready=0; release -> new instruction captured the next cycle.
- flush=1 with a valid instruction, load_use=1 and out_ready=0 -> in_ready=1, next out_valid=0, stall_cnt unchanged.
- NREG=16: WB writes x20, then read x20 -> 0; write x0=0xFF -> x0 still reads 0. Plus immediate checks: BEQ with offset -4 -> out_imm=0xFFFFFFFC; JAL +2048 -> out_imm=0x800.
